// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   ifu_state_e   fetch FSM encoding (request / wait for cache / hold for decode)
//   IFU_RESET_PC  default PC after reset
//   IFU_PC_STEP   default sequential PC increment in bytes
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int unsigned IFU_PC_STEP  = 4;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: 32-bit event counter with synchronous active-high reset.
// Ports:
//   clock  in   clock
//   reset  in   synchronous, active-high; clears the count
//   en     in   increment by one this cycle
//   count  out  current count, wraps mod 2^32
module ifu_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage in front of the I-cache.
// Owns the PC, pulses inst_require for one cycle per fetch, holds pc until inst_valid,
// buffers the returned word and offers {out_pc, out_inst} to decode over valid/ready.
// Redirects from EXU are applied immediately when idle in S_HOLD, or deferred until the
// in-flight cache access completes (the returned word is then dropped).
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   inst_require, pc             fetch pulse and address to the I-cache
//   inst_valid, inst             I-cache response pulse and data
//   out_valid, out_ready         handshake to decode
//   out_pc, out_inst             held instruction and its PC
//   redirect_valid, redirect_pc  control-flow change pulse and target
//   perf_fetch_cnt/wait_cnt/flush_cnt  event counters, present only with IFU_PERF_EN defined
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned PC_STEP  = IFU_PC_STEP
) (
    input  logic        clock,
    input  logic        reset,
    output logic        inst_require,
    output logic [31:0] pc,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        unique case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
                // The request is already out; the redirect must wait for its response.
                if (redirect_valid) begin
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = redirect_pc;
                end
                if (inst_valid) begin
                    if (redir_pend_q || redirect_valid) begin
                        // Newest redirect wins, including one arriving with the response.
                        pc_d         = redirect_valid ? redirect_pc : redir_tgt_q;
                        redir_pend_d = 1'b0;
                        state_d      = S_REQ;
                    end else begin
                        out_inst_d  = inst;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    pc_d        = redirect_pc;
                    state_d     = S_REQ;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_q + 32'(PC_STEP);
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign inst_require = (state_q == S_REQ);
    assign pc           = pc_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;

`ifdef IFU_PERF_EN
    logic fetch_ev;
    logic wait_ev;
    logic flush_ev;

    assign fetch_ev = out_valid_q && out_ready;
    assign wait_ev  = (state_q == S_WAIT);
    assign flush_ev = ((state_q == S_WAIT) && inst_valid && (redir_pend_q || redirect_valid))
                    || ((state_q == S_HOLD) && redirect_valid);

    ifu_perf_cnt u_fetch_cnt (
        .clock (clock),
        .reset (reset),
        .en    (fetch_ev),
        .count (perf_fetch_cnt)
    );

    ifu_perf_cnt u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .en    (wait_ev),
        .count (perf_wait_cnt)
    );

    ifu_perf_cnt u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .en    (flush_ev),
        .count (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch with a latency-programmable I-cache model and a
// scoreboard of expected {pc, inst} words checked whenever out_valid rises.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_require;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    // Cache model drive and a manual override for stale pulses.
    logic        model_iv = 1'b0;
    logic [31:0] model_inst = '0;
    logic        man_iv = 1'b0;
    logic [31:0] man_inst = '0;
    assign inst_valid = model_iv | man_iv;
    assign inst       = man_iv ? man_inst : model_inst;

    always #5 clock = ~clock;

    ifu_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .inst_require   (inst_require),
        .pc             (pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected {out_pc, out_inst}.
    logic [63:0] sb_q[$];

    task automatic expect_word(input logic [31:0] a);
        sb_q.push_back({a, mem_word(a)});
    endtask

    // Cache model: answers a request `latency` cycles after the request cycle.
    int          latency = 1;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_pc = '0;
    logic        rst_s, req_s;
    logic [31:0] pc_s;

    initial begin
        forever begin
            @(negedge clock);
            rst_s = reset;
            req_s = inst_require && !reset;
            pc_s  = pc;
            @(posedge clock);
            #1;
            model_iv = 1'b0;
            if (rst_s) busy = 1'b0;
            if (req_s) begin
                busy   = 1'b1;
                cnt    = latency;
                req_pc = pc_s;
            end
            if (busy) begin
                if (cnt <= 1) begin
                    model_iv   = 1'b1;
                    model_inst = mem_word(req_pc);
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Output monitor: every new out_valid presentation must match the scoreboard head.
    logic        prev_ov = 1'b0;
    logic [63:0] exp_e;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: out_pc %h presented, none expected",
                                 out_pc);
                    end else begin
                        exp_e = sb_q.pop_front();
                        chk("out_pc", out_pc, exp_e[63:32]);
                        chk("out_inst", out_inst, exp_e[31:0]);
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // Protocol monitor: single-cycle request pulses, pc held while waiting.
    logic        prev_req = 1'b0;
    logic        in_wait = 1'b0;
    logic [31:0] wait_pc = '0;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_req = 1'b0;
                in_wait  = 1'b0;
            end else begin
                if (prev_req) chk_bit("req_back_to_back", inst_require, 1'b0);
                if (in_wait) begin
                    chk("pc_stable_wait", pc, wait_pc);
                    if (inst_valid) in_wait = 1'b0;
                end
                if (inst_require) begin
                    in_wait = 1'b1;
                    wait_pc = pc;
                end
                prev_req = inst_require;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Leaves the bench #1 into post-reset cycle 0 (first S_REQ cycle).
    task automatic do_reset();
        step();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        man_iv         = 1'b0;
        step_n(2);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d words still expected after %0d cycles, required 0",
                     name, sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, first fetch with a one-cycle hit.
        latency   = 1;
        out_ready = 1'b0;
        expect_word(RST_PC);
        do_reset();
        @(negedge clock);
        chk_bit("t1_req_c0", inst_require, 1'b1);
        chk("t1_pc_c0", pc, RST_PC);
        chk_bit("t1_outv_c0", out_valid, 1'b0);
        chk("t1_outpc_rst", out_pc, 32'h0);
        chk("t1_outinst_rst", out_inst, 32'h0);
`ifdef IFU_PERF_EN
        chk("t1_fetch_cnt_rst", perf_fetch_cnt, 32'd0);
        chk("t1_wait_cnt_rst", perf_wait_cnt, 32'd0);
        chk("t1_flush_cnt_rst", perf_flush_cnt, 32'd0);
`endif
        step();
        @(negedge clock);
        chk_bit("t1_outv_c1", out_valid, 1'b0);
        chk_bit("t1_req_c1", inst_require, 1'b0);
        step();
        @(negedge clock);
        chk_bit("t1_outv_c2", out_valid, 1'b1);
        chk("t1_outpc_c2", out_pc, RST_PC);
        drain("t1_drain", 5);

        // 2: four back-to-back sequential fetches.
        for (int i = 0; i < 4; i++) expect_word(RST_PC + 32'(4 * i));
        do_reset();
        out_ready = 1'b1;
        drain("t2_drain", 40);

        // 3: redirect during a 10-cycle miss drops the returned word.
        latency   = 10;
        out_ready = 1'b1;
        expect_word(32'h8000_0100);
        do_reset();
        step_n(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        step_n(7);
        @(negedge clock);
        chk_bit("t3_req_after_drop", inst_require, 1'b1);
        chk("t3_pc_after_drop", pc, 32'h8000_0100);
        chk_bit("t3_no_outv", out_valid, 1'b0);
        drain("t3_drain", 30);

        // 4: held output stays stable; redirect beats a simultaneous out_ready.
        latency   = 1;
        out_ready = 1'b0;
        expect_word(RST_PC);
        expect_word(32'h8000_0200);
        do_reset();
        step_n(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk_bit("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_pc", out_pc, RST_PC);
            chk("t4_hold_inst", out_inst, mem_word(RST_PC));
            step();
        end
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(negedge clock);
        chk_bit("t4_req_after_redir", inst_require, 1'b1);
        chk("t4_pc_after_redir", pc, 32'h8000_0200);
        chk_bit("t4_outv_dropped", out_valid, 1'b0);
        out_ready = 1'b1;
        drain("t4_drain", 20);

        // 5: reset mid-wait, stale inst_valid in the first post-reset S_REQ cycle.
        latency   = 10;
        out_ready = 1'b1;
        expect_word(RST_PC);
        do_reset();
        step_n(3);
        reset = 1'b1;
        step_n(2);
        reset    = 1'b0;
        latency  = 1;
        man_iv   = 1'b1;
        man_inst = 32'hDEAD_BEEF;
        @(negedge clock);
        chk_bit("t5_req_c0", inst_require, 1'b1);
        chk("t5_pc_c0", pc, RST_PC);
        step();
        man_iv = 1'b0;
        @(negedge clock);
        chk_bit("t5_outv_c1", out_valid, 1'b0);
        drain("t5_drain", 10);

        // 7: PC increment wraps past 32'hFFFF_FFFC.
        latency   = 1;
        out_ready = 1'b0;
        expect_word(RST_PC);
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0000_0000);
        do_reset();
        step_n(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        drain("t7_drain", 20);

`ifdef IFU_PERF_EN
        // 6: three accepted, one flushed, two wait cycles per fetch.
        latency   = 2;
        out_ready = 1'b1;
        expect_word(RST_PC);
        expect_word(RST_PC + 32'd4);
        expect_word(32'h8000_0300);
        do_reset();
        step_n(9);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        redirect_valid = 1'b0;
        drain("t6_drain", 30);
        @(negedge clock);
        chk("t6_fetch_cnt", perf_fetch_cnt, 32'd3);
        chk("t6_flush_cnt", perf_flush_cnt, 32'd1);
        chk("t6_wait_cnt", perf_wait_cnt, 32'd8);
`endif

        do_reset();
        step_n(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
